// File: rtl/prio_event_encoder_pkg.sv
// prio_pkg: shared types and constants for prio_event_encoder.
//   state_t     : presenter FSM state (IDLE, PRESENT), also exported on the
//                 encoder's debug port.
//   PRIO_N_MIN/ : legal range of the request-line count N.
//   PRIO_N_MAX
package prio_pkg;

  localparam int PRIO_N_MIN = 2;
  localparam int PRIO_N_MAX = 64;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

endpackage

// File: rtl/prio_event_encoder_find.sv
// prio_find: combinational circular priority search.
// Scans cand starting at index 'start', moving downward and wrapping from
// 0 to N-1; reports the first set index found.
// Ports:
//   cand  [N]     candidate bits
//   start [IDX_W] first index examined (N-1 gives plain highest-index-wins)
//   idx   [IDX_W] winning index (0 when nothing found)
//   found         at least one candidate bit set
module prio_find #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     cand,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  int w_pos;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    w_pos = 0;
    for (int i = 0; i < N; i++) begin
      // Offset i below start, modulo N (start is always < N).
      if (int'(start) >= i) w_pos = int'(start) - i;
      else                  w_pos = int'(start) + N - i;
      if (!found && cand[IDX_W'(w_pos)]) begin
        idx   = IDX_W'(w_pos);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_event_encoder.sv
// prio_event_encoder: registered priority encoder with rising-edge capture.
// Rising edges on req are latched into a pending register; the winning
// unmasked pending index is presented on a valid/ready port and its pending
// bit is cleared when accepted.
//
// Handshake: out_idx is offered while out_valid is high and is held stable
// (independent of mask changes) until the cycle in which out_valid and
// out_ready are both high; that cycle is the accept. An accepted index is
// followed by one cycle with out_valid low before the next offer.
//
// Configuration macro: PRIO_ROTATE_EN
//   undefined : fixed priority, highest index wins.
//   defined   : rotating priority; search starts at a pointer that moves to
//               just below the most recently accepted index.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   req[N]     request lines, a 0->1 transition is an event
//   mask[N]    1 = excluded from selection (still captured as pending)
//   clr_all    synchronous clear of all pending state
//   out_idx    presented winner index
//   out_valid  out_idx is valid
//   out_ready  consumer accepts when out_valid && out_ready
//   pending[N] pending register
//   any_pend   OR of pending & ~mask
//   overflow   one-cycle pulse when an edge hits an already-pending bit
//   dbg_state  presenter FSM state
module prio_event_encoder
  import prio_pkg::*;
#(
  parameter  int N     = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  input  logic             clr_all,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     pending,
  output logic             any_pend,
  output logic             overflow,
  output state_t           dbg_state
);

  if (N < PRIO_N_MIN || N > PRIO_N_MAX) begin : g_bad_n
    $error("prio_event_encoder: N must be within 2..64");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N-1:0]     r_req_q;
  logic [N-1:0]     r_pending;
  logic [IDX_W-1:0] r_out_idx;
  logic             r_overflow;

  logic [N-1:0]     w_edge;
  logic [N-1:0]     w_cand;
  logic [N-1:0]     w_clr;
  logic             w_accept;
  logic             w_load;
  logic [IDX_W-1:0] w_start;
  logic [IDX_W-1:0] w_win_idx;
  logic             w_found;

  assign w_edge   = req & ~r_req_q;
  assign w_cand   = r_pending & ~mask;
  assign w_accept = (r_state == ST_PRESENT) && out_ready;
  assign w_clr    = w_accept ? ({{(N-1){1'b0}}, 1'b1} << r_out_idx) : '0;

`ifdef PRIO_ROTATE_EN
  logic [IDX_W-1:0] r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= IDX_W'(N-1);
    end else if (clr_all) begin
      r_ptr <= IDX_W'(N-1);
    end else if (w_accept) begin
      // Next search begins just below the index just served, wrapping.
      r_ptr <= (r_out_idx == '0) ? IDX_W'(N-1) : r_out_idx - 1'b1;
    end
  end

  assign w_start = r_ptr;
`else
  assign w_start = IDX_W'(N-1);
`endif

  prio_find #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_find (
    .cand  (w_cand),
    .start (w_start),
    .idx   (w_win_idx),
    .found (w_found)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state; w_load captures the winner on IDLE -> PRESENT.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    if (clr_all) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            w_load      = 1'b1;
            w_state_nxt = ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (out_ready) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Datapath registers. req_q follows req even under clr_all so that a
  // line held high across the clear does not produce a fresh event later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_q    <= '0;
      r_pending  <= '0;
      r_out_idx  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_req_q <= req;
      if (clr_all) begin
        r_pending  <= '0;
        r_overflow <= 1'b0;
      end else begin
        // Set wins over clear on the same bit.
        r_pending  <= (r_pending & ~w_clr) | w_edge;
        r_overflow <= |(w_edge & r_pending & ~w_clr);
      end
      if (w_load) r_out_idx <= w_win_idx;
    end
  end

  assign out_idx   = r_out_idx;
  assign out_valid = (r_state == ST_PRESENT);
  assign pending   = r_pending;
  assign any_pend  = |w_cand;
  assign overflow  = r_overflow;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_prio_event_encoder.sv
module tb_prio_event_encoder;
  import prio_pkg::*;

  localparam int N     = 8;
  localparam int IDX_W = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]     req = '0;
  logic [N-1:0]     mask = '0;
  logic             clr_all = 1'b0;
  logic             out_ready = 1'b0;
  logic [IDX_W-1:0] out_idx;
  logic             out_valid;
  logic [N-1:0]     pending;
  logic             any_pend;
  logic             overflow;
  state_t           dbg_state;

  prio_event_encoder #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mask      (mask),
    .clr_all   (clr_all),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pending   (pending),
    .any_pend  (any_pend),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  bit m_req_q [N];
  bit m_pend  [N];
  bit m_present;
  int m_idx;
  bit m_ovf;
  int m_ptr;

  logic [IDX_W-1:0] exp_q[$];

  task automatic model_reset();
    for (int b = 0; b < N; b++) begin
      m_req_q[b] = 1'b0;
      m_pend[b]  = 1'b0;
    end
    m_present = 1'b0;
    m_idx     = 0;
    m_ovf     = 1'b0;
    m_ptr     = N - 1;
  endtask

  // Winner among pending & ~mk: walk downward from the start index with wrap.
  function automatic int pick_winner(logic [N-1:0] mk);
    int start;
`ifdef PRIO_ROTATE_EN
    start = m_ptr;
`else
    start = N - 1;
`endif
    for (int k = 0; k < N; k++) begin
      int p;
      p = (start - k + N) % N;
      if (m_pend[p] && !mk[p]) return p;
    end
    return -1;
  endfunction

  task automatic model_clock(input logic [N-1:0] r, input logic [N-1:0] mk,
                             input logic rdy, input logic cl);
    bit accept;
    int win;
    bit ev;
    accept = m_present && rdy;
    win    = pick_winner(mk);
    if (cl) begin
      for (int b = 0; b < N; b++) m_pend[b] = 1'b0;
      m_present = 1'b0;
      m_ovf     = 1'b0;
      m_ptr     = N - 1;
    end else begin
      m_ovf = 1'b0;
      for (int b = 0; b < N; b++) begin
        ev = r[b] && !m_req_q[b];
        if (ev) begin
          if (m_pend[b] && !(accept && b == m_idx)) m_ovf = 1'b1;
          m_pend[b] = 1'b1;
        end else if (accept && b == m_idx) begin
          m_pend[b] = 1'b0;
        end
      end
      if (m_present) begin
        if (accept) begin
          m_present = 1'b0;
          m_ptr     = (m_idx == 0) ? N - 1 : m_idx - 1;
        end
      end else if (win >= 0) begin
        m_idx     = win;
        m_present = 1'b1;
      end
    end
    for (int b = 0; b < N; b++) m_req_q[b] = r[b];
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [N-1:0] ep;
    for (int b = 0; b < N; b++) ep[b] = m_pend[b];
    chk("out_valid", 64'(out_valid), 64'(m_present));
    chk("out_idx",   64'(out_idx),   64'(m_idx));
    chk("pending",   64'(pending),   64'(ep));
    chk("any_pend",  64'(any_pend),  64'(|(ep & ~mask)));
    chk("overflow",  64'(overflow),  64'(m_ovf));
    chk("dbg_state", 64'(dbg_state == ST_PRESENT), 64'(m_present));
  endtask

  // ---------------- driver ----------------
  task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] mk,
                     input logic rdy, input logic cl);
    req       = r;
    mask      = mk;
    out_ready = rdy;
    clr_all   = cl;
    @(posedge clk);
    model_clock(r, mk, rdy, cl);
    #1;
    check_all();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_valid"},   64'(out_valid), 64'(0));
    chk({tag, "_idx"},     64'(out_idx),   64'(0));
    chk({tag, "_pending"}, 64'(pending),   64'(0));
    chk({tag, "_anyp"},    64'(any_pend),  64'(0));
    chk({tag, "_ovf"},     64'(overflow),  64'(0));
  endtask

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] mk;

    // Reset state.
    #2;
    check_reset_values("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Two simultaneous events: 5 then 2, with a bubble between grants.
    cyc(8'h24, 8'h00, 1'b0, 1'b0);
    chk("p1_pend", 64'(pending), 64'h24);
    chk("p1_novalid", 64'(out_valid), 64'(0));
    cyc(8'h00, 8'h00, 1'b0, 1'b0);
    chk("p1_idx5", 64'(out_idx), 64'(5));
    chk("p1_valid5", 64'(out_valid), 64'(1));
    cyc(8'h00, 8'h00, 1'b1, 1'b0);
    chk("p1_bubble", 64'(out_valid), 64'(0));
    cyc(8'h00, 8'h00, 1'b0, 1'b0);
    chk("p1_idx2", 64'(out_idx), 64'(2));
    cyc(8'h00, 8'h00, 1'b1, 1'b0);
    chk("p1_anyp0", 64'(any_pend), 64'(0));

    // Masked event is captured but not presented until unmasked.
    cyc(8'h80, 8'h80, 1'b0, 1'b0);
    cyc(8'h80, 8'h80, 1'b0, 1'b0);
    chk("p2_pend7", 64'(pending[7]), 64'(1));
    chk("p2_novalid", 64'(out_valid), 64'(0));
    cyc(8'h00, 8'h00, 1'b0, 1'b0);
    chk("p2_idx7", 64'(out_idx), 64'(7));
    cyc(8'h00, 8'h00, 1'b1, 1'b0);

    // Presented index held stable across new events and mask changes.
    cyc(8'h08, 8'h00, 1'b0, 1'b0);
    cyc(8'h00, 8'h00, 1'b0, 1'b0);
    cyc(8'h40, 8'h08, 1'b0, 1'b0);
    cyc(8'h40, 8'h08, 1'b0, 1'b0);
    chk("p3_hold3", 64'(out_idx), 64'(3));
    cyc(8'h00, 8'h08, 1'b1, 1'b0);
    cyc(8'h00, 8'h08, 1'b0, 1'b0);
    chk("p3_idx6", 64'(out_idx), 64'(6));
    cyc(8'h00, 8'h00, 1'b1, 1'b0);

    // Overflow pulse on a re-edge of a pending bit; one grant only.
    cyc(8'h10, 8'h00, 1'b0, 1'b0);
    cyc(8'h00, 8'h00, 1'b0, 1'b0);
    cyc(8'h10, 8'h00, 1'b0, 1'b0);
    chk("p4_ovf1", 64'(overflow), 64'(1));
    cyc(8'h00, 8'h00, 1'b0, 1'b0);
    chk("p4_ovf0", 64'(overflow), 64'(0));
    cyc(8'h00, 8'h00, 1'b1, 1'b0);
    cyc(8'h00, 8'h00, 1'b0, 1'b0);
    chk("p4_nogrant", 64'(out_valid), 64'(0));
    chk("p4_pend0", 64'(pending), 64'(0));

    // clr_all during PRESENT.
    cyc(8'h2A, 8'h00, 1'b0, 1'b0);
    cyc(8'h00, 8'h00, 1'b0, 1'b0);
    cyc(8'h00, 8'h00, 1'b0, 1'b1);
    chk("p5_clr_valid", 64'(out_valid), 64'(0));
    chk("p5_clr_pend", 64'(pending), 64'(0));
    cyc(8'h00, 8'h00, 1'b0, 1'b0);

    // Asynchronous reset mid-PRESENT.
    cyc(8'h40, 8'h00, 1'b0, 1'b0);
    cyc(8'h00, 8'h00, 1'b0, 1'b0);
    chk("p6_present", 64'(out_valid), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("midrst");
    #1;
    rst = 1'b0;
    model_reset();

    // Grant order with bits 7, 4, 1 continuously re-pended.
`ifdef PRIO_ROTATE_EN
    exp_q = '{3'd7, 3'd4, 3'd1, 3'd7};
`else
    exp_q = '{3'd7, 3'd7, 3'd7, 3'd7};
`endif
    cyc(8'h00, 8'h00, 1'b0, 1'b1);
    cyc(8'h00, 8'h00, 1'b0, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      cyc((c % 2 == 1) ? 8'h92 : 8'h00, 8'h00, 1'b1, 1'b0);
      if (c % 2 == 0) begin
        chk("order_valid", 64'(out_valid), 64'(1));
        chk("order_idx", 64'(out_idx), 64'(exp_q.pop_front()));
      end
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      r  = N'($urandom & $urandom);
      mk = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      cyc(r, mk, 1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
